mem_lsu_sb: RTL and testbench
=============================

Name: mem_lsu_sb

Overview:
- Parametrised successor to the single-request memory stage.
- Sits between EX/MEM pipeline register and the data cache port.
- Adds: posted store buffer (SB_DEPTH entries), store-to-load forwarding, load byte/half extraction with sign extension, and a load FSM.
- The pipeline stalls only on buffer full, cache load miss/latency, or a partial forwarding hazard.

Parameters:
- ADDR_W, 32: byte address width; word index is addr[ADDR_W-1:2].
- SB_DEPTH, 4: store buffer entries, power of two, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory op presented this cycle.
- req_read  in  1  op is load.
- req_write  in  1  op is store (never both with req_read).
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  rs2 value, unshifted.
- stall_out  out  1  hold upstream; op not accepted this cycle.
- load_valid  out  1  one-cycle pulse, load result ready.
- load_data  out  32  extracted/extended load result.
- sb_empty  out  1  store buffer holds no entries.
- misalign  out  1  misaligned-access pulse (see Optional Feature).
- mem_read  out  1  cache read request.
- mem_write  out  1  cache write request.
- mem_wmask  out  4  byte enables for write.
- mem_address  out  ADDR_W  word-aligned address (low 2 bits 0).
- mem_wdata  out  32  write data, lane-shifted.
- mem_resp  in  1  cache completes current request.
- mem_rdata  in  32  cache read data, valid with mem_resp.

Behaviour:
- Reset (async, rst_n=0): SB count/head/tail=0; state IDLE; all outputs 0; sb_empty=1. Any cache transaction in flight is abandoned.
- Accept: a cycle with req_valid=1 and stall_out=0. Ops with req_read=req_write=0 are accepted with no effect.
- Store, SB not full: accepted the same cycle (stall_out=0). Enqueues {word addr, wdata shifted by addr[1:0], mask}. Masks: B 0001<<a[1:0]; H 0011<<a[1:0]; W 1111.
- Store, SB full: stall_out=1. If a dequeue and an enqueue happen in the same cycle, both occur and count is unchanged.
- SB drain: when state IDLE and no load is waiting for the port, the head entry drives mem_write/mem_address/mem_wdata/mem_wmask. The request is held stable until mem_resp, then dequeued.
- Load lookup: compare the word address against all valid SB entries.
  - Youngest match whose mask covers all load bytes: forward with no cache access. Accepted the same cycle; load_valid/load_data next cycle.
  - No match: FSM IDLE->LOAD. Hold stall_out=1 and mem_read=1 from the next cycle until mem_resp. The mem_resp cycle is the accept cycle; load_valid follows next cycle.
  - Youngest match with partial cover: IDLE->DRAIN. Stall until sb_empty=1, then proceed as the no-match case.
- Port arbitration: a drain write already issued completes before a load issues (no abort). Otherwise a waiting load wins over drain.
- FSM: IDLE, LOAD (mem_read held until mem_resp, then IDLE), DRAIN (SB drains; go to LOAD when sb_empty).
- Extraction: select lane by addr[1:0]. B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- load_data holds its value between pulses. load_valid is never asserted in two consecutive cycles for the same op.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: H with addr[0]=1 or W with addr[1:0]!=0 is accepted without stalling. It raises misalign for one cycle (the cycle after accept), makes no SB change, issues no cache request, and raises no load_valid.
- Undefined: misalign tied 0. Addresses are force-aligned: H clears addr[0], W clears addr[1:0].

Test Plan:
- Reset, then 4 stores SW to 0x100..0x10C with mem_resp held 0 -> all accepted without stall. 5th store stalls. Raise mem_resp for one cycle -> 0x100 written with mask 1111 and the 5th store is accepted.
- SB empty, LW 0x200, mem_resp after 3 cycles with rdata 0xDEADBEEF -> stall_out=1 for 4 cycles, load_valid next cycle, load_data=0xDEADBEEF.
- SW 0x300=0x12345678 buffered, then LB 0x301 -> no mem_read, load_valid next cycle, load_data=0x00000056. LH 0x302 -> 0x00001234.
- SB 0x400=0x80 buffered, then LW 0x400 -> DRAIN: write mask 0001 completes, then mem_read issues; result equals mem_rdata.
- LB 0x503 with rdata 0x80000000 -> 0xFFFFFF80. LBU -> 0x00000080. LHU 0x502 with rdata 0xFFFF0000 -> 0x0000FFFF.
- MEM_MISALIGN_TRAP_EN defined, LW 0x601 -> misalign pulses once, no mem_read, no load_valid. Undefined -> mem_address=0x600 and a normal load completes.

Source files
------------

// File: rtl/mem_lsu_sb_if.sv
// Bundle between the EX/MEM pipeline, the load/store unit and the data cache port.
interface mem_lsu_sb_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_read;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall_out;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              sb_empty;
    logic              misalign;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        mem_wmask;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wdata;
    logic              mem_resp;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        output mem_resp, mem_rdata,
        input  stall_out, load_valid, load_data, sb_empty, misalign,
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata
    );

    modport slave (
        input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        input  mem_resp, mem_rdata,
        output stall_out, load_valid, load_data, sb_empty, misalign,
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_lsu_sb.sv
// Memory stage: posted store buffer, store-to-load forwarding, load extraction and load FSM.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module mem_lsu_sb #(
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    mem_lsu_sb_if.slave bus
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int WA_W  = ADDR_W - 2;

    // state | meaning
    // IDLE  | accept ops, drain store buffer when no load waits for the port
    // LOAD  | cache read held until mem_resp
    // DRAIN | partial forward hazard, empty the store buffer before loading
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
    state_t state, state_nxt;

    logic [WA_W-1:0]  sb_addr [SB_DEPTH];
    logic [31:0]      sb_data [SB_DEPTH];
    logic [3:0]       sb_mask [SB_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             wr_busy;
    logic [WA_W-1:0]  ld_word;
    logic [1:0]       ld_off;
    logic [2:0]       ld_f3;
    logic             load_valid_q, misalign_q;
    logic [31:0]      load_data_q;

    logic [ADDR_W-1:0] eff_addr;
    logic              mis;
    logic [1:0]        off;
    logic [3:0]        acc_mask;
    logic              is_ld, is_st;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o,
                                            input logic [2:0] f3);
        logic [31:0] s;
        s = w >> {o, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        eff_addr = bus.req_addr;
        mis      = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
              (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
        if (bus.req_funct3[1:0] == 2'b01) eff_addr[0] = 1'b0;
        if (bus.req_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        off = eff_addr[1:0];
        case (bus.req_funct3[1:0])
            2'b00:   acc_mask = 4'b0001 << off;
            2'b01:   acc_mask = 4'b0011 << off;
            default: acc_mask = 4'b1111;
        endcase
    end

    assign is_ld = bus.req_valid && bus.req_read && !mis;
    assign is_st = bus.req_valid && bus.req_write && !mis;

    // Walk oldest to youngest so the last match left standing is the youngest.
    logic             hit;
    logic [3:0]       hit_mask;
    logic [31:0]      hit_data;
    logic [PTR_W-1:0] idx;
    always_comb begin
        hit      = 1'b0;
        hit_mask = 4'b0000;
        hit_data = 32'h0;
        idx      = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (i < int'(count) && sb_addr[idx] == eff_addr[ADDR_W-1:2]) begin
                hit      = 1'b1;
                hit_mask = sb_mask[idx];
                hit_data = sb_data[idx];
            end
        end
    end

    logic fwd, ld_miss, full, empty, drain_en, deq, enq, stall;
    assign fwd     = hit && ((hit_mask & acc_mask) == acc_mask);
    assign ld_miss = is_ld && !fwd;
    assign full    = count == (PTR_W+1)'(SB_DEPTH);
    assign empty   = count == '0;
    // An already issued write always finishes; otherwise a waiting load owns the port.
    assign drain_en = !empty && (state == DRAIN || (state == IDLE && (wr_busy || !ld_miss)));
    assign deq      = drain_en && bus.mem_resp;
    assign enq      = state == IDLE && is_st && !stall;

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        bus.mem_read = 1'b0;
        case (state)
            IDLE: begin
                if (ld_miss) begin
                    stall = 1'b1;
                    if (hit) state_nxt = DRAIN;
                    else if (!wr_busy || bus.mem_resp) state_nxt = LOAD;
                end else if (is_st && full && !deq) begin
                    stall = 1'b1;
                end
            end
            LOAD: begin
                bus.mem_read = 1'b1;
                stall        = !bus.mem_resp;
                if (bus.mem_resp) state_nxt = IDLE;
            end
            DRAIN: begin
                stall = 1'b1;
                if (empty) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            wr_busy      <= 1'b0;
            ld_word      <= '0;
            ld_off       <= 2'b00;
            ld_f3        <= 3'b000;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'h0;
            misalign_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_busy    <= drain_en && !bus.mem_resp;
            misalign_q <= bus.req_valid && mis && !stall;
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state == IDLE && ld_miss) begin
                ld_word <= eff_addr[ADDR_W-1:2];
                ld_off  <= off;
                ld_f3   <= bus.req_funct3;
            end
            load_valid_q <= 1'b0;
            if (state == IDLE && is_ld && fwd) begin
                load_valid_q <= 1'b1;
                load_data_q  <= extract(hit_data, off, bus.req_funct3);
            end else if (state == LOAD && bus.mem_resp) begin
                load_valid_q <= 1'b1;
                load_data_q  <= extract(bus.mem_rdata, ld_off, ld_f3);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr[tail] <= eff_addr[ADDR_W-1:2];
            sb_data[tail] <= bus.req_wdata << {off, 3'b000};
            sb_mask[tail] <= acc_mask;
        end
    end

    assign bus.stall_out   = stall;
    assign bus.load_valid  = load_valid_q;
    assign bus.load_data   = load_data_q;
    assign bus.sb_empty    = empty;
    assign bus.misalign    = misalign_q;
    assign bus.mem_write   = drain_en;
    assign bus.mem_wmask   = drain_en ? sb_mask[head] : 4'b0000;
    assign bus.mem_wdata   = drain_en ? sb_data[head] : 32'h0;
    assign bus.mem_address = drain_en ? {sb_addr[head], 2'b00} :
                             (state == LOAD) ? {ld_word, 2'b00} : '0;
endmodule

// File: tb/tb_mem_lsu_sb.sv
// Directed bench for mem_lsu_sb: store buffering/drain, load miss, forwarding, drain hazard, extraction.
module tb_mem_lsu_sb;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    mem_lsu_sb_if #(.ADDR_W(32)) bus ();

    mem_lsu_sb #(.ADDR_W(32), .SB_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = v;
        bus.req_read   = rd;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    // Load that misses the empty buffer; cache answers after n_wait read cycles.
    task automatic miss_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rdata, input int n_wait,
                             input logic [31:0] exp_addr, input logic [31:0] exp);
        set_req(1, 1, 0, f3, a, 0);
        #1;
        chk({tag, " stall_first"}, bus.stall_out, 1);
        chk({tag, " no_read_first"}, bus.mem_read, 0);
        for (int i = 0; i < n_wait; i++) begin
            tick();
            chk({tag, " stall_wait"}, bus.stall_out, 1);
            chk({tag, " mem_read"}, bus.mem_read, 1);
            chk({tag, " mem_address"}, bus.mem_address, exp_addr);
        end
        tick();
        bus.mem_resp  = 1;
        bus.mem_rdata = rdata;
        #1;
        chk({tag, " accept_on_resp"}, bus.stall_out, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        bus.mem_resp = 0;
        #1;
        chk({tag, " load_valid"}, bus.load_valid, 1);
        chk({tag, " load_data"}, bus.load_data, exp);
    endtask

    initial begin
        rst_n = 0;
        set_req(0, 0, 0, 0, 0, 0);
        bus.mem_resp  = 0;
        bus.mem_rdata = 0;
        #12;
        chk("rst stall", bus.stall_out, 0);
        chk("rst load_valid", bus.load_valid, 0);
        chk("rst load_data", bus.load_data, 0);
        chk("rst sb_empty", bus.sb_empty, 1);
        chk("rst mem_write", bus.mem_write, 0);
        chk("rst mem_read", bus.mem_read, 0);
        chk("rst misalign", bus.misalign, 0);
        #6 rst_n = 1;
        tick();

        // Four stores fill the buffer while the cache stays silent.
        for (int k = 0; k < 4; k++) begin
            set_req(1, 0, 1, 3'b010, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
            #1;
            chk("sw no stall", bus.stall_out, 0);
            tick();
        end
        set_req(1, 0, 1, 3'b010, 32'h110, 32'hA4);
        #1;
        chk("sw5 stall full", bus.stall_out, 1);
        chk("drain mem_write", bus.mem_write, 1);
        chk("drain addr", bus.mem_address, 32'h100);
        chk("drain mask", bus.mem_wmask, 4'hF);
        chk("drain data", bus.mem_wdata, 32'hA0);
        tick();
        bus.mem_resp = 1;
        #1;
        chk("sw5 accepted on dequeue", bus.stall_out, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        bus.mem_resp = 0;
        #1;
        chk("next head addr", bus.mem_address, 32'h104);
        chk("sb not empty", bus.sb_empty, 0);
        bus.mem_resp = 1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("drain seq addr", bus.mem_address, 32'h104 + 32'(4 * j));
            tick();
        end
        bus.mem_resp = 0;
        #1;
        chk("drained empty", bus.sb_empty, 1);
        chk("drained no write", bus.mem_write, 0);

        // No-op request passes without effect.
        set_req(1, 0, 0, 3'b010, 32'h180, 32'h1);
        #1;
        chk("noop no stall", bus.stall_out, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        chk("noop sb_empty", bus.sb_empty, 1);

        miss_load("lw miss", 3'b010, 32'h200, 32'hDEADBEEF, 3, 32'h200, 32'hDEADBEEF);
        tick();
        chk("lw single pulse", bus.load_valid, 0);
        chk("lw data held", bus.load_data, 32'hDEADBEEF);

        // Forwarding from a buffered word.
        set_req(1, 0, 1, 3'b010, 32'h300, 32'h12345678);
        #1;
        chk("sw 300 no stall", bus.stall_out, 0);
        tick();
        set_req(1, 1, 0, 3'b000, 32'h301, 0);
        #1;
        chk("lb fwd no stall", bus.stall_out, 0);
        chk("lb fwd no read", bus.mem_read, 0);
        tick();
        set_req(1, 1, 0, 3'b001, 32'h302, 0);
        #1;
        chk("lb fwd valid", bus.load_valid, 1);
        chk("lb fwd data", bus.load_data, 32'h00000056);
        chk("lh fwd no stall", bus.stall_out, 0);
        chk("lh fwd no read", bus.mem_read, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        chk("lh fwd valid", bus.load_valid, 1);
        chk("lh fwd data", bus.load_data, 32'h00001234);
        bus.mem_resp = 1;
        tick();
        bus.mem_resp = 0;
        #1;
        chk("300 drained", bus.sb_empty, 1);

        // Partial cover forces a drain before the load.
        set_req(1, 0, 1, 3'b000, 32'h400, 32'h80);
        tick();
        set_req(1, 1, 0, 3'b010, 32'h400, 0);
        #1;
        chk("partial stall", bus.stall_out, 1);
        chk("partial load wins port", bus.mem_write, 0);
        tick();
        chk("drain write", bus.mem_write, 1);
        chk("drain wmask", bus.mem_wmask, 4'b0001);
        chk("drain wdata", bus.mem_wdata, 32'h80);
        chk("drain waddr", bus.mem_address, 32'h400);
        chk("drain stall", bus.stall_out, 1);
        bus.mem_resp = 1;
        tick();
        bus.mem_resp = 0;
        #1;
        chk("drain done no read yet", bus.mem_read, 0);
        chk("drain done stall", bus.stall_out, 1);
        tick();
        chk("hazard read", bus.mem_read, 1);
        chk("hazard read addr", bus.mem_address, 32'h400);
        bus.mem_resp  = 1;
        bus.mem_rdata = 32'hCAFE0080;
        #1;
        chk("hazard accept", bus.stall_out, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        bus.mem_resp = 0;
        #1;
        chk("hazard valid", bus.load_valid, 1);
        chk("hazard data", bus.load_data, 32'hCAFE0080);
        tick();

        miss_load("lb sext", 3'b000, 32'h503, 32'h80000000, 1, 32'h500, 32'hFFFFFF80);
        tick();
        miss_load("lbu", 3'b100, 32'h503, 32'h80000000, 1, 32'h500, 32'h00000080);
        tick();
        miss_load("lhu", 3'b101, 32'h502, 32'hFFFF0000, 1, 32'h500, 32'h0000FFFF);
        tick();
        miss_load("lh sext", 3'b001, 32'h502, 32'hFFFF0000, 1, 32'h500, 32'hFFFFFFFF);
        tick();

`ifdef MEM_MISALIGN_TRAP_EN
        set_req(1, 1, 0, 3'b010, 32'h601, 0);
        #1;
        chk("mis no stall", bus.stall_out, 0);
        chk("mis no read", bus.mem_read, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        chk("mis pulse", bus.misalign, 1);
        chk("mis no load_valid", bus.load_valid, 0);
        chk("mis no read after", bus.mem_read, 0);
        tick();
        chk("mis single pulse", bus.misalign, 0);
        chk("mis sb_empty", bus.sb_empty, 1);
`else
        miss_load("lw aligned", 3'b010, 32'h601, 32'h11223344, 1, 32'h600, 32'h11223344);
        chk("no misalign", bus.misalign, 0);
        tick();
        chk("aligned single pulse", bus.load_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
